// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage.
package mips_pkg;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {FETCH, WAIT} fetch_state_e;

endpackage

// File: rtl/npc.sv
// Combinational next-PC selection: sequential, branch, jump or register target.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_d,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] ext_out,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        case (npc_sel)
            NPC_BR: begin
                if (br_taken) begin
                    next_pc  = pc_d + 32'd4 + ext_out;
                    redirect = 1'b1;
                end
            end
            NPC_J: begin
                next_pc  = {pc_d[31:28], ext_out[27:0]};
                redirect = 1'b1;
            end
            NPC_JR: begin
                next_pc  = jr_target;
                redirect = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a FETCH/WAIT memory handshake.
// Define BRANCH_DELAY_SLOT_EN for delay-slot semantics; otherwise taken redirects squash the slot.
module if_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] ext_out,
    input  logic [31:0] jr_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_ready,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        valid_D
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  dpc_q, dpc_d;
    logic [31:0]  link_q, link_d;
    logic         dvalid_q, dvalid_d;
    logic         rpend_q, rpend_d;
    logic [31:0]  rpc_q, rpc_d;

    logic [31:0]  next_pc;
    logic         redirect;
    logic         advance;
    logic         take_word;

    npc u_npc (
        .pc        (fpc_q),
        .pc_d      (dpc_q),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .ext_out   (ext_out),
        .jr_target (jr_target),
        .next_pc   (next_pc),
        .redirect  (redirect)
    );

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        inst_d   = inst_q;
        dpc_d    = dpc_q;
        link_d   = link_q;
        dvalid_d = dvalid_q;
        rpend_d  = rpend_q;
        rpc_d    = rpc_q;

        advance   = !stall && im_ready;
`ifdef BRANCH_DELAY_SLOT_EN
        take_word = advance && !flush;
`else
        // The word arriving alongside a taken redirect is the slot; drop it.
        take_word = advance && !flush && !(redirect || rpend_q);
`endif

        if (!stall) begin
            if (im_ready) begin
                fpc_d   = rpend_q ? rpc_q : next_pc;
                state_d = FETCH;
                rpend_d = 1'b0;
                rpc_d   = '0;
            end else begin
                state_d = WAIT;
                // Decode will show a bubble next cycle, so remember the target now.
                if (redirect) begin
                    rpend_d = 1'b1;
                    rpc_d   = next_pc;
                end
            end
        end

        if (take_word) begin
            inst_d   = im_rdata;
            dpc_d    = fpc_q;
            link_d   = fpc_q + 32'd8;
            dvalid_d = 1'b1;
        end else if (flush || !stall) begin
            inst_d   = NOP_WORD;
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            fpc_q    <= PC_RESET;
            inst_q   <= NOP_WORD;
            dpc_q    <= '0;
            link_q   <= 32'd8;
            dvalid_q <= 1'b0;
            rpend_q  <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            inst_q   <= inst_d;
            dpc_q    <= dpc_d;
            link_q   <= link_d;
            dvalid_q <= dvalid_d;
            rpend_q  <= rpend_d;
            rpc_q    <= rpc_d;
        end
    end

    assign im_addr = fpc_q;
    assign IR_D    = inst_q;
    assign PC_D    = dpc_q;
    assign PC8_D   = link_q;
    assign valid_D = dvalid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed scoreboard bench for if_stage; expectations follow BRANCH_DELAY_SLOT_EN when defined.
module tb_if_stage;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0, im_ready = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [31:0] ext_out = '0, jr_target = '0, im_rdata = '0;
    logic [31:0] im_addr, IR_D, PC_D, PC8_D;
    logic        valid_D;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pcd;
        logic        v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .npc_sel(npc_sel), .br_taken(br_taken), .ext_out(ext_out),
        .jr_target(jr_target), .im_addr(im_addr), .im_rdata(im_rdata),
        .im_ready(im_ready), .IR_D(IR_D), .PC_D(PC_D), .PC8_D(PC8_D),
        .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hAA00_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " im_addr"}, im_addr, e.pc);
        chk({tag, " IR_D"}, IR_D, e.ir);
        chk({tag, " PC_D"}, PC_D, e.pcd);
        chk({tag, " PC8_D"}, PC8_D, e.pcd + 32'd8);
        chk({tag, " valid_D"}, {31'b0, valid_D}, {31'b0, e.v});
    endtask

    // Monitor: after each active edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all("step", e);
            end
        end
    end

    task automatic step(input logic [1:0] sel, input logic tk, input logic [31:0] ext,
                        input logic [31:0] jr, input logic [31:0] rd, input logic rdy,
                        input logic stl, input logic fl, input logic [31:0] e_pc,
                        input logic [31:0] e_ir, input logic [31:0] e_pcd, input logic e_v);
        exp_t e;
        @(negedge clk);
        npc_sel = sel; br_taken = tk; ext_out = ext; jr_target = jr;
        im_rdata = rd; im_ready = rdy; stall = stl; flush = fl;
        e.pc = e_pc; e.ir = e_ir; e.pcd = e_pcd; e.v = e_v;
        q.push_back(e);
    endtask

    initial begin
        exp_t r;
        r.pc = 32'h3000; r.ir = 32'h0; r.pcd = 32'h0; r.v = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", r);
        reset = 1'b0;

        // Sequential fetch
        step(2'b00, 0, 0, 0, w(32'h3000), 1, 0, 0, 32'h3004, w(32'h3000), 32'h3000, 1);
        step(2'b00, 0, 0, 0, w(32'h3004), 1, 0, 0, 32'h3008, w(32'h3004), 32'h3004, 1);
        step(2'b00, 0, 0, 0, w(32'h3008), 1, 0, 0, 32'h300C, w(32'h3008), 32'h3008, 1);
        step(2'b00, 0, 0, 0, w(32'h300C), 1, 0, 0, 32'h3010, w(32'h300C), 32'h300C, 1);
        step(2'b00, 0, 0, 0, w(32'h3010), 1, 0, 0, 32'h3014, w(32'h3010), 32'h3010, 1);
        // Taken branch at 3010: 3010+4-16 = 3004
        step(2'b01, 1, 32'hFFFF_FFF0, 0, w(32'h3014), 1, 0, 0, 32'h3004,
             DS ? w(32'h3014) : 32'h0, DS ? 32'h3014 : 32'h3010, DS);
        step(2'b00, 0, 0, 0, w(32'h3004), 1, 0, 0, 32'h3008, w(32'h3004), 32'h3004, 1);
        // Not-taken branch falls through
        step(2'b01, 0, 32'hFFFF_FFF0, 0, w(32'h3008), 1, 0, 0, 32'h300C, w(32'h3008), 32'h3008, 1);
        // Jump from 3008 to 0000_4000
        step(2'b10, 0, 32'h0000_4000, 0, w(32'h300C), 1, 0, 0, 32'h4000,
             DS ? w(32'h300C) : 32'h0, DS ? 32'h300C : 32'h3008, DS);
        step(2'b00, 0, 0, 0, w(32'h4000), 1, 0, 0, 32'h4004, w(32'h4000), 32'h4000, 1);
        // Register jump to 3100
        step(2'b11, 0, 0, 32'h3100, w(32'h4004), 1, 0, 0, 32'h3100,
             DS ? w(32'h4004) : 32'h0, DS ? 32'h4004 : 32'h4000, DS);
        step(2'b00, 0, 0, 0, w(32'h3100), 1, 0, 0, 32'h3104, w(32'h3100), 32'h3100, 1);
        // Stall two cycles with a taken branch held in decode, then release
        step(2'b01, 1, 32'h20, 0, w(32'h3104), 1, 1, 0, 32'h3104, w(32'h3100), 32'h3100, 1);
        step(2'b01, 1, 32'h20, 0, w(32'h3104), 1, 1, 0, 32'h3104, w(32'h3100), 32'h3100, 1);
        step(2'b01, 1, 32'h20, 0, w(32'h3104), 1, 0, 0, 32'h3124,
             DS ? w(32'h3104) : 32'h0, DS ? 32'h3104 : 32'h3100, DS);
        step(2'b00, 0, 0, 0, w(32'h3124), 1, 0, 0, 32'h3128, w(32'h3124), 32'h3124, 1);
        // Stall + flush: bubble, PC held; flush alone: bubble, PC advances
        step(2'b00, 0, 0, 0, w(32'h3128), 1, 1, 1, 32'h3128, 32'h0, 32'h3124, 0);
        step(2'b00, 0, 0, 0, w(32'h3128), 1, 0, 1, 32'h312C, 32'h0, 32'h3124, 0);
        step(2'b00, 0, 0, 0, w(32'h312C), 1, 0, 0, 32'h3130, w(32'h312C), 32'h312C, 1);
        // Jump to 5000 while memory not ready for three cycles
        step(2'b10, 0, 32'h0000_5000, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h3130, 32'h0, 32'h312C, 0);
        step(2'b00, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h3130, 32'h0, 32'h312C, 0);
        step(2'b00, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h3130, 32'h0, 32'h312C, 0);
        step(2'b00, 0, 0, 0, w(32'h3130), 1, 0, 0, 32'h5000,
             DS ? w(32'h3130) : 32'h0, DS ? 32'h3130 : 32'h312C, DS);
        step(2'b00, 0, 0, 0, w(32'h5000), 1, 0, 0, 32'h5004, w(32'h5000), 32'h5000, 1);
        // Enter WAIT, then reset asynchronously mid-cycle
        step(2'b00, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h5004, 32'h0, 32'h5000, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async reset", r);
        @(negedge clk);
        reset = 1'b0;
        step(2'b00, 0, 0, 0, w(32'h3000), 1, 0, 0, 32'h3004, w(32'h3000), 32'h3000, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
